// File: rtl/srf02_pkg.sv
// Shared definitions for the SRF02 ultrasonic range sequencer.
//   - seq_state_t        : sequencer FSM state encoding
//   - SRF02_CMD_RANGE_CM : command byte the write engine sends to register 0
//   - SRF02_NODATA       : value the sensor returns when no echo was seen
//   - ABORT_CYC          : cycles i2c_abort is held after a timeout
//   - GUARD_CYC          : cycles a done level is ignored after a start pulse
//   - cnt_width()        : cycle-counter width for a given parameter set
package srf02_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WR_GO,
      WR_WAIT,
      RANGING,
      RD_GO,
      RD_WAIT,
      HOLDOFF,
      ABORT
   } seq_state_t;

   localparam logic [7:0]  SRF02_CMD_RANGE_CM = 8'h51;
   localparam logic [15:0] SRF02_NODATA       = 16'hFFFF;
   localparam int          ABORT_CYC          = 4;
   localparam int          GUARD_CYC          = 2;

   // One spare bit above the largest threshold so the saturated value is
   // always strictly beyond every compare point.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = ABORT_CYC;
      if (a > m) m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m + 1) + 1;
   endfunction

endpackage

// File: rtl/seq_counter.sv
// Loadable, saturating up-counter used for both the phase and period timers.
// Ports:
//   i_clk      : system clock
//   i_rst_n    : synchronous active-low reset, clears the count
//   i_load     : load i_load_val this cycle (wins over counting)
//   i_load_val : value to load
//   i_en       : count enable
//   o_count    : current count; sticks at all-ones instead of wrapping
module seq_counter #(
   parameter int W = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != {W{1'b1}})) begin
         r_count <= r_count + W'(1);
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/srf02_range_sequencer.sv
// SRF02 range sequencer: triggers the command-write engine (0x51 to reg 0),
// waits out the ranging time, triggers the range-read engine and publishes
// the result. Supports single-shot (trig) and continuous (enable) operation
// with per-transaction timeouts and sticky error flags.
// Ports:
//   clk, reset           : system clock, synchronous active-low reset
//   enable, trig         : continuous mode level / single-shot pulse
//   wr_start, wr_done    : command-write engine handshake
//   rd_start, rd_done    : range-read engine handshake, rd_data = raw range
//   i2c_abort            : resets both engines (timeout or reset)
//   range, range_valid   : last good range (cm) and its one-cycle strobe
//   busy                 : high whenever not IDLE
//   err_timeout          : sticky, an engine failed to finish in time
//   err_nodata           : sticky, sensor returned the no-echo value
//
// state   | meaning
// IDLE    | waiting for enable or trig
// WR_GO   | one-cycle wr_start pulse, phase and period timers restart
// WR_WAIT | waiting for wr_done (guarded), timeout watched
// RANGING | sensor measuring, wait WAIT_CYC from write-done
// RD_GO   | one-cycle rd_start pulse
// RD_WAIT | waiting for rd_done (guarded), timeout watched
// HOLDOFF | continuous mode, wait for the period to elapse
// ABORT   | i2c_abort held for ABORT_CYC cycles
module srf02_range_sequencer
   import srf02_pkg::*;
#(
   parameter int WAIT_CYC    = 3_500_000,
   parameter int PERIOD_CYC  = 5_000_000,
   parameter int TIMEOUT_CYC = 50_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        trig,
   output logic        wr_start,
   input  logic        wr_done,
   output logic        rd_start,
   input  logic        rd_done,
   input  logic [15:0] rd_data,
   output logic        i2c_abort,
   output logic [15:0] range,
   output logic        range_valid,
   output logic        busy,
   output logic        err_timeout,
   output logic        err_nodata
);

   localparam int CW = cnt_width(WAIT_CYC, PERIOD_CYC, TIMEOUT_CYC);

   localparam logic [CW-1:0] C_ONE       = CW'(1);
   localparam logic [CW-1:0] C_GUARD     = CW'(GUARD_CYC);
   localparam logic [CW-1:0] C_WAIT_END  = CW'(WAIT_CYC - 1);
   localparam logic [CW-1:0] C_PER_END   = CW'(PERIOD_CYC - 1);
   localparam logic [CW-1:0] C_TMO_END   = CW'(TIMEOUT_CYC - 1);
   localparam logic [CW-1:0] C_ABORT_END = CW'(ABORT_CYC - 1);

   seq_state_t    r_state;
   seq_state_t    w_next_state;

   logic [CW-1:0] w_ph_cnt;
   logic [CW-1:0] w_per_cnt;
   logic          w_ph_load;
   logic [CW-1:0] w_ph_load_val;
   logic          w_per_load;

   logic          w_guard_ok;
   logic          w_tmo_hit;
   logic          w_wr_accept;
   logic          w_rd_accept;
   logic          w_rd_good;
   logic          w_set_tmo;
   logic          w_err_clr;

   logic [15:0]   r_range;
   logic          r_range_valid;
   logic          r_err_timeout;
   logic          r_err_nodata;

   assign w_guard_ok = (w_ph_cnt >= C_GUARD);
   assign w_tmo_hit  = (w_ph_cnt >= C_TMO_END);
   assign w_rd_good  = (rd_data != SRF02_NODATA);

   always_comb begin
      w_next_state = r_state;
      w_wr_accept  = 1'b0;
      w_rd_accept  = 1'b0;
      w_set_tmo    = 1'b0;
      w_err_clr    = 1'b0;
      case (r_state)
         IDLE: begin
            if (enable || trig) begin
               w_next_state = WR_GO;
               w_err_clr    = trig;
            end
         end
         WR_GO: begin
            w_next_state = WR_WAIT;
         end
         WR_WAIT: begin
            if (w_guard_ok && wr_done) begin
               w_wr_accept  = 1'b1;
               w_next_state = RANGING;
            end else if (w_tmo_hit) begin
               w_set_tmo    = 1'b1;
               w_next_state = ABORT;
            end
         end
         RANGING: begin
            if (w_ph_cnt >= C_WAIT_END) begin
               w_next_state = RD_GO;
            end
         end
         RD_GO: begin
            w_next_state = RD_WAIT;
         end
         RD_WAIT: begin
            if (w_guard_ok && rd_done) begin
               w_rd_accept  = 1'b1;
               w_next_state = enable ? HOLDOFF : IDLE;
            end else if (w_tmo_hit) begin
               w_set_tmo    = 1'b1;
               w_next_state = ABORT;
            end
         end
         HOLDOFF: begin
            if (!enable) begin
               w_next_state = IDLE;
            end else if (w_per_cnt >= C_PER_END) begin
               w_next_state = WR_GO;
            end
         end
         ABORT: begin
            if (w_ph_cnt >= C_ABORT_END) begin
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // The phase timer restarts on every state change. Entering RANGING it
   // starts at 1 because the wr_done cycle itself is the first cycle of the
   // ranging wait, so rd_start lands exactly WAIT_CYC cycles after it.
   assign w_ph_load     = (w_next_state != r_state);
   assign w_ph_load_val = w_wr_accept ? C_ONE : '0;

   // Period timer reads k in the k-th cycle after wr_start.
   assign w_per_load = (r_state == WR_GO);

   seq_counter #(.W(CW)) u_phase_cnt (
      .i_clk      (clk),
      .i_rst_n    (reset),
      .i_load     (w_ph_load),
      .i_load_val (w_ph_load_val),
      .i_en       (1'b1),
      .o_count    (w_ph_cnt)
   );

   seq_counter #(.W(CW)) u_period_cnt (
      .i_clk      (clk),
      .i_rst_n    (reset),
      .i_load     (w_per_load),
      .i_load_val (C_ONE),
      .i_en       (1'b1),
      .o_count    (w_per_cnt)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_range       <= SRF02_NODATA;
         r_range_valid <= 1'b0;
         r_err_timeout <= 1'b0;
         r_err_nodata  <= 1'b0;
      end else begin
         r_state       <= w_next_state;
         r_range_valid <= w_rd_accept && w_rd_good;
         if (w_rd_accept && w_rd_good) begin
            r_range <= rd_data;
         end
         if (w_err_clr) begin
            r_err_timeout <= 1'b0;
            r_err_nodata  <= 1'b0;
         end
         if (w_set_tmo) begin
            r_err_timeout <= 1'b1;
         end
         if (w_rd_accept && !w_rd_good) begin
            r_err_nodata <= 1'b1;
         end
      end
   end

   assign wr_start    = (r_state == WR_GO);
   assign rd_start    = (r_state == RD_GO);
   assign busy        = (r_state != IDLE);
   // Asserted combinationally during reset so a mid-transaction engine is
   // returned to idle even before the first clock edge of reset.
   assign i2c_abort   = !reset || (r_state == ABORT);
   assign range       = r_range;
   assign range_valid = r_range_valid;
   assign err_timeout = r_err_timeout;
   assign err_nodata  = r_err_nodata;

endmodule

// File: tb/tb_srf02_range_sequencer.sv
module tb_srf02_range_sequencer;

   localparam int WAIT_CYC    = 100;
   localparam int PERIOD_CYC  = 300;
   localparam int TIMEOUT_CYC = 50;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic        trig = 1'b0;
   logic        wr_start;
   logic        wr_done = 1'b0;
   logic        rd_start;
   logic        rd_done = 1'b0;
   logic [15:0] rd_data = 16'h0000;
   logic        i2c_abort;
   logic [15:0] range;
   logic        range_valid;
   logic        busy;
   logic        err_timeout;
   logic        err_nodata;

   srf02_range_sequencer #(
      .WAIT_CYC    (WAIT_CYC),
      .PERIOD_CYC  (PERIOD_CYC),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .trig        (trig),
      .wr_start    (wr_start),
      .wr_done     (wr_done),
      .rd_start    (rd_start),
      .rd_done     (rd_done),
      .rd_data     (rd_data),
      .i2c_abort   (i2c_abort),
      .range       (range),
      .range_valid (range_valid),
      .busy        (busy),
      .err_timeout (err_timeout),
      .err_nodata  (err_nodata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_tests = 0;
   int          n_fail = 0;
   int          n_wr = 0;
   int          n_rd = 0;
   int          n_valid = 0;
   int          last_valid = -1;
   logic [15:0] exp_q[$];
   logic [15:0] mon_exp;

   // Scoreboard side: every range_valid strobe must match the oldest
   // expected range; starts must never overlap.
   always @(negedge clk) begin
      if (wr_start) n_wr++;
      if (rd_start) n_rd++;
      if (wr_start || rd_start) begin
         n_tests++;
         assert (!(wr_start && rd_start)) else begin
            n_fail++;
            $error("FAIL start_excl: wr_start=%b rd_start=%b, required not both", wr_start, rd_start);
         end
      end
      if (range_valid) begin
         n_valid++;
         last_valid = cyc;
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL valid_unexpected: range_valid=1 range=%h, required no strobe", range);
         end else begin
            mon_exp = exp_q.pop_front();
            assert (range === mon_exp) else begin
               n_fail++;
               $error("FAIL range_value: got %h required %h", range, mon_exp);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h required %0h", tag, got, exp);
      end
   endtask

   task automatic goto(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wait_wr(input int budget, output int t);
      t = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (wr_start) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL wait_wr: got no wr_start in %0d cycles, required one", budget);
      end
   endtask

   task automatic wait_rd(input int budget, output int t);
      t = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (rd_start) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         n_tests++;
         n_fail++;
         $error("FAIL wait_rd: got no rd_start in %0d cycles, required one", budget);
      end
   endtask

   // Engine model: wr_done 10 cycles after wr_start, rd_done 5 cycles
   // after rd_start; rd_start must come WAIT_CYC cycles after wr_done.
   task automatic xact(input string pfx, input int t, input logic [15:0] data,
                       input bit expect_valid, output int tr);
      goto(t + 10);
      wr_done = 1'b1;
      goto(t + 11);
      wr_done = 1'b0;
      wait_rd(150, tr);
      chk({pfx, "_rd_lat"}, 32'(tr), 32'(t + 10 + WAIT_CYC));
      goto(tr + 5);
      rd_data = data;
      rd_done = 1'b1;
      if (expect_valid) exp_q.push_back(data);
      goto(tr + 6);
      rd_done = 1'b0;
   endtask

   initial begin
      int c0, t, tr, prev, nrd, nval;
      logic [15:0] d;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_wr_start", 32'(wr_start), 32'(0));
      chk("rst_rd_start", 32'(rd_start), 32'(0));
      chk("rst_valid", 32'(range_valid), 32'(0));
      chk("rst_range", 32'(range), 32'(16'hFFFF));
      chk("rst_abort", 32'(i2c_abort), 32'(1));
      chk("rst_err_tmo", 32'(err_timeout), 32'(0));
      chk("rst_err_nd", 32'(err_nodata), 32'(0));
      reset = 1'b1;
      @(negedge clk);
      chk("rel_abort", 32'(i2c_abort), 32'(0));

      // Single shot, trig during WR_WAIT ignored
      c0 = cyc;
      trig = 1'b1;
      wait_wr(5, t);
      trig = 1'b0;
      chk("s1_wr_lat", 32'(t), 32'(c0 + 1));
      chk("s1_busy", 32'(busy), 32'(1));
      goto(t + 5);
      trig = 1'b1;
      goto(t + 6);
      trig = 1'b0;
      xact("s1", t, 16'h00A5, 1'b1, tr);
      chk("s1_range", 32'(range), 32'(16'h00A5));
      chk("s1_valid", 32'(range_valid), 32'(1));
      chk("s1_idle", 32'(busy), 32'(0));
      @(negedge clk);
      chk("s1_valid_1cyc", 32'(range_valid), 32'(0));
      repeat (20) @(negedge clk);
      chk("s1_no_requeue", 32'(n_wr), 32'(1));

      // No data
      trig = 1'b1;
      wait_wr(5, t);
      trig = 1'b0;
      xact("s2", t, 16'hFFFF, 1'b0, tr);
      chk("s2_err_nd", 32'(err_nodata), 32'(1));
      chk("s2_range_kept", 32'(range), 32'(16'h00A5));
      chk("s2_idle", 32'(busy), 32'(0));
      repeat (10) @(negedge clk);
      chk("s2_err_sticky", 32'(err_nodata), 32'(1));
      chk("s2_no_valid", 32'(n_valid), 32'(1));

      // Stale done levels on both engines: guards must hold
      wr_done = 1'b1;
      rd_done = 1'b1;
      rd_data = 16'h1234;
      exp_q.push_back(16'h1234);
      trig = 1'b1;
      wait_wr(5, t);
      trig = 1'b0;
      chk("s3_err_clr", 32'(err_nodata), 32'(0));
      wait_rd(150, tr);
      chk("s3_wr_guard", 32'(tr), 32'(t + 3 + WAIT_CYC));
      goto(tr + 5);
      chk("s3_rd_guard", 32'(last_valid), 32'(tr + 4));
      chk("s3_range", 32'(range), 32'(16'h1234));
      wr_done = 1'b0;
      rd_done = 1'b0;

      // Continuous mode over 3 periods
      c0 = cyc;
      enable = 1'b1;
      wait_wr(5, t);
      chk("s4_wr_lat", 32'(t), 32'(c0 + 1));
      prev = t;
      for (int i = 1; i <= 3; i++) begin
         d = 16'h0100 + 16'(i);
         xact("s4", prev, d, 1'b1, tr);
         wait_wr(400, t);
         chk("s4_period", 32'(t - prev), 32'(PERIOD_CYC));
         prev = t;
      end
      enable = 1'b0;

      // Timeout on the last write: wr_done never comes
      goto(prev + 50);
      chk("s5_tmo_early", 32'(err_timeout), 32'(0));
      chk("s5_abort_early", 32'(i2c_abort), 32'(0));
      goto(prev + 51);
      chk("s5_err_tmo", 32'(err_timeout), 32'(1));
      for (int k = 51; k <= 54; k++) begin
         goto(prev + k);
         chk("s5_abort_hold", 32'(i2c_abort), 32'(1));
      end
      goto(prev + 55);
      chk("s5_abort_end", 32'(i2c_abort), 32'(0));
      chk("s5_idle", 32'(busy), 32'(0));

      // Reset mid-RANGING; enable start leaves sticky error untouched
      enable = 1'b1;
      wait_wr(5, t);
      chk("s6_err_sticky", 32'(err_timeout), 32'(1));
      goto(t + 10);
      wr_done = 1'b1;
      goto(t + 11);
      wr_done = 1'b0;
      goto(t + 40);
      reset = 1'b0;
      enable = 1'b0;
      goto(t + 41);
      chk("s6_abort_rst", 32'(i2c_abort), 32'(1));
      chk("s6_idle", 32'(busy), 32'(0));
      chk("s6_err_clr", 32'(err_timeout), 32'(0));
      reset = 1'b1;
      nrd = n_rd;
      nval = n_valid;
      goto(t + 200);
      chk("s6_no_rd", 32'(n_rd), 32'(nrd));
      chk("s6_no_valid", 32'(n_valid), 32'(nval));
      chk("s6_range", 32'(range), 32'(16'hFFFF));

      chk("q_empty", 32'(exp_q.size()), 32'(0));
      chk("valid_total", 32'(n_valid), 32'(5));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
